// File: rtl/reverb_tap_loader_pkg.sv
// Shared types and helpers for the reverb tap loader.
package reverb_tap_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STREAM,
    WAIT_DONE,
    DONE
  } tap_ld_state_t;

  // Number of taps for a given log2 tap count.
  function automatic int num_taps(input int taps_log2);
    return 1 << taps_log2;
  endfunction

endpackage

// File: rtl/reverb_tap_loader_if.sv
// Tap stream link between the loader (master) and the FIR tap_din port (slave).
interface reverb_tap_loader_if #(
  parameter int G_TAP_WIDTH = 16
);
  logic [G_TAP_WIDTH-1:0] tap_dout;
  logic                   tap_dout_valid;
  logic                   tap_dout_ready;
  logic                   tap_fir_done;

  modport master (
    output tap_dout, tap_dout_valid,
    input  tap_dout_ready, tap_fir_done
  );

  modport slave (
    input  tap_dout, tap_dout_valid,
    output tap_dout_ready, tap_fir_done
  );
endinterface

// File: rtl/reverb_tap_loader_tap_ram.sv
// Tap storage: 1W/1R simple dual-port RAM with a registered, enabled read port.
// The read register doubles as the outgoing tap, so holding rd_en low holds the beat.
module reverb_tap_loader_tap_ram
  import reverb_tap_loader_pkg::*;
#(
  parameter int G_ADDR_W = 4,
  parameter int G_DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clr,
  input  logic                i_wr_en,
  input  logic [G_ADDR_W-1:0] i_wr_addr,
  input  logic [G_DATA_W-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic [G_ADDR_W-1:0] i_rd_addr,
  output logic [G_DATA_W-1:0] o_rd_data
);
  localparam int DEPTH = num_taps(G_ADDR_W);

  logic [G_DATA_W-1:0] r_mem [DEPTH];
  logic [G_DATA_W-1:0] r_rd_data;

  // Storage array is never reset; contents survive reset and soft clear.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read; cleared so the stream output reads 0 when idle after clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_rd_data <= '0;
    else if (i_clr)   r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/reverb_tap_loader.sv
// Reverb tap loader: host fills a local tap RAM, start streams every tap in
// ascending order to the FIR, then waits for the FIR's done acknowledge.
// Optional watchdog: define REVERB_TAP_LOADER_TIMEOUT_EN.
module reverb_tap_loader
  import reverb_tap_loader_pkg::*;
#(
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_TIMEOUT_LOG2  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_enable,
  input  logic                       i_cfg_wr_en,
  input  logic [G_NUM_TAPS_LOG2-1:0] i_cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     i_cfg_wr_data,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_load_done,
  output logic                       o_load_error,
  reverb_tap_loader_if.master        tap
);
  tap_ld_state_t              r_state, w_next;
  logic [G_NUM_TAPS_LOG2-1:0] r_beat;
  logic                       r_valid, r_load_done, r_load_error;
  logic                       w_idle_like, w_start_ok, w_hs, w_last, w_timeout;
  logic                       w_wr_en, w_rd_en;
  logic [G_NUM_TAPS_LOG2-1:0] w_rd_addr;
  logic [G_TAP_WIDTH-1:0]     w_rd_data;

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
  assign w_start_ok  = i_start && w_idle_like;
  assign w_hs        = r_valid && tap.tap_dout_ready;
  assign w_last      = w_hs && (&r_beat);
  assign o_busy      = (r_state == STREAM) || (r_state == WAIT_DONE);

`ifdef REVERB_TAP_LOADER_TIMEOUT_EN
  logic [G_TIMEOUT_LOG2-1:0] r_wd;

  // Watchdog: counts busy cycles since the last accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_wd <= '0;
    else if (!i_enable || w_start_ok) r_wd <= '0;
    else if (o_busy)                 r_wd <= r_wd + G_TIMEOUT_LOG2'(1);
  end

  assign w_timeout = o_busy && (&r_wd);
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state plus RAM port control; the read port prefetches the next tap
  // on every handshake so a continuously ready FIR gets one tap per cycle.
  always_comb begin
    w_next    = r_state;
    w_wr_en   = i_cfg_wr_en && w_idle_like;
    w_rd_en   = 1'b0;
    w_rd_addr = r_beat + G_NUM_TAPS_LOG2'(1);
    if (!i_enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (i_start) w_next = FETCH;
        FETCH: begin
          w_next    = STREAM;
          w_rd_en   = 1'b1;
          w_rd_addr = '0;
        end
        STREAM: begin
          w_rd_en = w_hs && !w_last;
          if (w_timeout)   w_next = DONE;
          else if (w_last) w_next = WAIT_DONE;
        end
        WAIT_DONE: if (w_timeout || tap.tap_fir_done) w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Beat counter, valid flag and sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !i_enable) begin
      r_beat       <= '0;
      r_valid      <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_beat       <= '0;
        r_load_done  <= 1'b0;
        r_load_error <= 1'b0;
      end
      if (r_state == FETCH) r_valid <= 1'b1;
      if (r_state == STREAM) begin
        if (w_timeout) begin
          r_valid      <= 1'b0;
          r_load_error <= 1'b1;
        end else if (w_hs) begin
          r_beat <= r_beat + G_NUM_TAPS_LOG2'(1);
          if (w_last) r_valid <= 1'b0;
        end
      end
      if (r_state == WAIT_DONE) begin
        if (w_timeout)              r_load_error <= 1'b1;
        else if (tap.tap_fir_done)  r_load_done  <= 1'b1;
      end
    end
  end

  reverb_tap_loader_tap_ram #(
    .G_ADDR_W (G_NUM_TAPS_LOG2),
    .G_DATA_W (G_TAP_WIDTH)
  ) u_tap_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (!i_enable),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (i_cfg_wr_addr),
    .i_wr_data (i_cfg_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign tap.tap_dout       = w_rd_data;
  assign tap.tap_dout_valid = r_valid;
  assign o_load_done        = r_load_done;
  assign o_load_error       = r_load_error;
endmodule

// File: tb/tb_reverb_tap_loader.sv
// Directed + randomized bench for reverb_tap_loader against a tap-array model.
module tb_reverb_tap_loader;
  localparam int NL = 4;
  localparam int W  = 16;
  localparam int NT = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          wr_en = 1'b0;
  logic [NL-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic          busy, load_done, load_error;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] model [NT];
  logic [W-1:0] got   [NT];
  int           nb;

  reverb_tap_loader_if #(.G_TAP_WIDTH(W)) tap ();

  reverb_tap_loader #(
    .G_NUM_TAPS_LOG2 (NL),
    .G_TAP_WIDTH     (W),
    .G_TIMEOUT_LOG2  (6)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_enable      (enable),
    .i_cfg_wr_en   (wr_en),
    .i_cfg_wr_addr (wr_addr),
    .i_cfg_wr_data (wr_data),
    .i_start       (start),
    .o_busy        (busy),
    .o_load_done   (load_done),
    .o_load_error  (load_error),
    .tap           (tap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle-time host write; always lands, so the model follows it.
  task automatic host_wr(input logic [NL-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start pulse, optionally with a same-cycle write; checks valid low in FETCH.
  task automatic do_start(input logic wr, input logic [NL-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    start = 1'b1;
    if (wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      model[a] = d;
    end
    chk("start_cycle_valid_low", 32'(tap.tap_dout_valid), 32'd0);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk("fetch_cycle_valid_low", 32'(tap.tap_dout_valid), 32'd0);
  endtask

  // Accept beats with ready asserted pct% of cycles until stop beats seen.
  // At cycle poke_at a busy-time write, a stray start and an early fir_done are driven.
  task automatic collect(input int pct, input int stop, input int poke_at, output int ncyc);
    logic         hold;
    logic [W-1:0] hold_d;
    hold = 1'b0; hold_d = '0; nb = 0; ncyc = 0;
    for (int c = 0; c < 400 && nb < stop; c++) begin
      @(negedge clk);
      ncyc++;
      if (hold) begin
        chk("hold_valid", 32'(tap.tap_dout_valid), 32'd1);
        chk("hold_data", 32'(tap.tap_dout), 32'(hold_d));
      end
      wr_en = (c == poke_at); start = (c == poke_at); tap.tap_fir_done = (c == poke_at);
      wr_addr = 4'd5; wr_data = 16'h7FFF;
      tap.tap_dout_ready = ($urandom_range(99) < pct);
      hold = 1'b0;
      if (tap.tap_dout_valid) begin
        if (tap.tap_dout_ready) begin
          got[nb] = tap.tap_dout;
          nb++;
        end else begin
          hold = 1'b1; hold_d = tap.tap_dout;
        end
      end
    end
    wr_en = 1'b0; start = 1'b0; tap.tap_fir_done = 1'b0;
    chk("beat_count", 32'(nb), 32'(stop));
  endtask

  task automatic cmp_stream();
    for (int k = 0; k < NT; k++) chk($sformatf("tap%0d", k), 32'(got[k]), 32'(model[k]));
  endtask

  // After the last beat: no extra beat, waits for fir_done, then DONE.
  task automatic finish_load();
    @(negedge clk);
    tap.tap_dout_ready = 1'b1;
    chk("no_extra_beat", 32'(tap.tap_dout_valid), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_not_done", 32'(load_done), 32'd0);
    tap.tap_fir_done = 1'b1;
    @(negedge clk);
    tap.tap_fir_done = 1'b0;
    chk("load_done_set", 32'(load_done), 32'd1);
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    int ncyc;
    tap.tap_dout_ready = 1'b0;
    tap.tap_fir_done   = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_valid", 32'(tap.tap_dout_valid), 32'd0);
    chk("rst_dout", 32'(tap.tap_dout), 32'd0);
    reset_n = 1'b1;

    // 1: ramp taps, full ready, one beat per cycle
    for (int k = 0; k < NT; k++) host_wr(NL'(k), W'(k * 3 + 1));
    do_start(1'b0, '0, '0);
    collect(100, NT, -1, ncyc);
    chk("full_rate_cycles", 32'(ncyc), 32'(NT));
    cmp_stream();
    finish_load();

    // 2: same taps, random 50% ready
    do_start(1'b0, '0, '0);
    collect(50, NT, -1, ncyc);
    cmp_stream();
    finish_load();

    // random tap values, sparse ready
    for (int k = 0; k < NT; k++) host_wr(NL'(k), W'($urandom));
    do_start(1'b0, '0, '0);
    collect(30, NT, -1, ncyc);
    cmp_stream();
    finish_load();

    // 3: stray start, write and early fir_done while streaming are all ignored
    do_start(1'b0, '0, '0);
    collect(100, NT, 3, ncyc);
    cmp_stream();
    @(negedge clk);
    chk("early_done_ignored", 32'(busy), 32'd1);
    finish_load();
    do_start(1'b0, '0, '0);
    collect(70, NT, -1, ncyc);
    cmp_stream();
    finish_load();

    // 4: async reset at beat 7 aborts; RAM survives, reload from tap 0
    do_start(1'b0, '0, '0);
    collect(100, 7, -1, ncyc);
    reset_n = 1'b0;
    #1;
    chk("abort_valid", 32'(tap.tap_dout_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_start(1'b0, '0, '0);
    collect(100, NT, -1, ncyc);
    cmp_stream();
    finish_load();

    // 5: write tap 0 in the start cycle
    do_start(1'b1, '0, 16'h8000);
    collect(60, NT, -1, ncyc);
    chk("same_cycle_wr_beat0", 32'(got[0]), 32'h8000);
    cmp_stream();
    finish_load();

    // soft clear mid-stream, then reload
    do_start(1'b0, '0, '0);
    collect(100, 5, -1, ncyc);
    enable = 1'b0;
    @(negedge clk);
    chk("clr_valid", 32'(tap.tap_dout_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_dout", 32'(tap.tap_dout), 32'd0);
    enable = 1'b1;
    do_start(1'b0, '0, '0);
    collect(100, NT, -1, ncyc);
    cmp_stream();
    finish_load();

    // 6: FIR never acknowledges
    do_start(1'b0, '0, '0);
    collect(100, NT, -1, ncyc);
    repeat (80) @(negedge clk);
`ifdef REVERB_TAP_LOADER_TIMEOUT_EN
    chk("wd_error", 32'(load_error), 32'd1);
    chk("wd_no_done", 32'(load_done), 32'd0);
    chk("wd_not_busy", 32'(busy), 32'd0);
`else
    chk("no_wd_busy", 32'(busy), 32'd1);
    chk("no_wd_error", 32'(load_error), 32'd0);
    finish_load();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
